apb_slave_mem: RTL and testbench
================================

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 Parameter ADDR_WIDTH, 8, width of paddr in bits (byte address).
REQ-002 Parameter DATA_WIDTH, 32, width of pwdata/prdata in bits.
REQ-003 Parameter DEPTH, 16, number of DATA_WIDTH-bit words in internal storage; DEPTH SHALL be at most 2^(ADDR_WIDTH-2).
REQ-004 Parameter WAIT_STATES, 1, number of access-phase cycles with pready low before completion; legal range 0-15.
REQ-005 Clock and reset SHALL be as follows: one clock, pclk; reset preset_n is asynchronous and active-low.
REQ-006 pclk  input  1  rising-edge clock for all state.
REQ-007 preset_n  input  1  asynchronous active-low reset.
REQ-008 pselx  input  1  slave select from the APB bridge.
REQ-009 penable  input  1  access-phase indicator.
REQ-010 pwrite  input  1  1 = write, 0 = read.
REQ-011 paddr  input  ADDR_WIDTH  byte address; word index = paddr[ADDR_WIDTH-1:2].
REQ-012 pwdata  input  DATA_WIDTH  write data.
REQ-013 pready  output  1  transfer-complete indication.
REQ-014 pslverr  output  1  transfer-error indication, valid only while pready=1.
REQ-015 prdata  output  DATA_WIDTH  read data, valid only while pready=1 and pwrite=0.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS.
REQ-017 In IDLE, pselx=1 and penable=0 at a rising edge (setup) SHALL capture paddr, pwrite and pwdata, load the wait counter with WAIT_STATES, and move to ACCESS.
REQ-018 In IDLE, penable=1 without a preceding setup SHALL be ignored; FSM stays in IDLE and pready stays 0.
REQ-019 In ACCESS with pselx=1 and penable=1 and counter != 0, the counter SHALL decrement by 1 per cycle and pready SHALL be 0.
REQ-020 pready SHALL be a decode of (state==ACCESS and counter==0); with WAIT_STATES=0 it is high in the first access cycle.
REQ-021 A transfer SHALL complete at the rising edge where pselx, penable and pready are all 1; FSM then returns to IDLE.
REQ-022 Back-to-back: a setup phase in the cycle after completion SHALL be accepted with no idle cycle in between.
REQ-023 Error condition: captured word index >= DEPTH, or captured paddr[1:0] != 0.
REQ-024 pslverr SHALL equal the error condition while pready=1, and 0 otherwise.
REQ-025 A non-error write SHALL update mem[index] with the captured pwdata at the completion edge; an error write SHALL leave memory unchanged.
REQ-026 prdata SHALL equal mem[index] while pready=1, pwrite=0 and no error; otherwise prdata SHALL be all zeros.
REQ-027 If pselx drops to 0 while in ACCESS before completion, the transfer SHALL be aborted: FSM returns to IDLE, no memory write, pready stays 0.
REQ-028 The captured address, direction and data SHALL be used for the whole transfer; changes to paddr, pwrite or pwdata during ACCESS SHALL have no effect.

Reset
REQ-029 preset_n=0 SHALL immediately force FSM=IDLE, counter=0, pready=0, pslverr=0, prdata=0, independent of pclk.
REQ-030 Reset SHALL clear every mem word to 0.
REQ-031 Reset asserted mid-transfer SHALL discard that transfer with no write; the first setup after preset_n rises SHALL be accepted normally.

Verification
REQ-032 Write 0xDEADBEEF to paddr 0x08, WAIT_STATES=1 -> pready low 1 access cycle then high, pslverr=0; a read of 0x08 returns prdata=0xDEADBEEF.
REQ-033 Read paddr 0x40 (index 16, DEPTH=16) -> pready high after wait, pslverr=1, prdata=0; no memory word changes.
REQ-034 Write 0x12345678 to paddr 0x05 (misaligned) -> pslverr=1; a read of 0x04 still returns its previous value.
REQ-035 Back-to-back write 0x0000_00AA to 0x00 then read 0x00 with no idle cycle -> both complete, read returns 0x000000AA.
REQ-036 Start a write of 0xFFFFFFFF to 0x0C, drop pselx during the wait cycle -> no completion; a read of 0x0C returns 0x00000000.
REQ-037 Assert preset_n=0 in ACCESS after writing 0x11 to 0x00 -> outputs go to 0 asynchronously; after release, a read of 0x00 returns 0x00000000.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB slave with a small word-addressed register memory and a fixed number of wait states.
// Address, direction and write data are captured at setup and held for the whole transfer.
module apb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] prdata
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic IDLE   = 1'b0;
  localparam logic ACCESS = 1'b1;

  logic                  state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  err;
  logic                  complete;
  logic                  mem_we;

  assign idx      = addr_q[ADDR_WIDTH-1:2];
  assign mem_idx  = idx[MEM_AW-1:0];
  assign err      = (32'(idx) >= DEPTH) || (addr_q[1:0] != 2'b00);
  assign pready   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign complete = pready && pselx && penable;
  assign mem_we   = complete && write_q && !err;
  assign pslverr  = pready && err;
  // mem_idx may be out of range when err is set; the mux keeps that value off the bus.
  assign prdata   = (pready && !write_q && !err) ? mem_q[mem_idx] : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (pselx && !penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
        end
      end
      ACCESS: begin
        if (!pselx) begin
          // Master withdrew the select: abandon the transfer without touching memory.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one task per scenario, inputs driven on the falling edge
// and outputs sampled on the falling edge, away from the active rising edge.
module tb_apb_slave_mem;

  logic        pclk;
  logic        preset_n;
  logic        pselx;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int n_checks = 0;
  int n_fail   = 0;

  apb_slave_mem #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .DEPTH      (16),
    .WAIT_STATES(1)
  ) dut (
    .pclk    (pclk),
    .preset_n(preset_n),
    .pselx   (pselx),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pready  (pready),
    .pslverr (pslverr),
    .prdata  (prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Full transfer up to the cycle where pready is seen high; completion happens at the next
  // rising edge. Inputs are scrambled during ACCESS so only captured values may matter.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int waits);
    @(negedge pclk);
    pselx   = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    @(negedge pclk);
    penable = 1'b1;
    pwrite  = ~wr;
    paddr   = ~addr;
    pwdata  = ~wd;
    waits   = 0;
    while (pready !== 1'b1 && waits < 20) begin
      waits++;
      @(negedge pclk);
    end
    rd  = prdata;
    err = pslverr;
  endtask

  task automatic go_idle();
    @(negedge pclk);
    pselx   = 1'b0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    pselx    = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = 8'h00;
    pwdata   = 32'h0;
    repeat (2) @(negedge pclk);
    n_checks++;
    if (pready !== 1'b0) begin
      n_fail++; $display("FAIL reset_pready: got %b expected 0", pready);
    end
    n_checks++;
    if (pslverr !== 1'b0) begin
      n_fail++; $display("FAIL reset_pslverr: got %b expected 0", pslverr);
    end
    n_checks++;
    if (prdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_prdata: got %h expected 00000000", prdata);
    end
    preset_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic        err;
    int          waits;
    apb_xfer(1'b1, 8'h08, 32'hDEADBEEF, rd, err, waits);
    go_idle();
    n_checks++;
    if (waits !== 1) begin
      n_fail++; $display("FAIL wr08_waits: got %0d expected 1", waits);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL wr08_pslverr: got %b expected 0", err);
    end
    apb_xfer(1'b0, 8'h08, 32'h0, rd, err, waits);
    go_idle();
    n_checks++;
    if (waits !== 1) begin
      n_fail++; $display("FAIL rd08_waits: got %0d expected 1", waits);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL rd08_pslverr: got %b expected 0", err);
    end
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd08_prdata: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    logic        err;
    int          waits;
    apb_xfer(1'b0, 8'h40, 32'h0, rd, err, waits);
    go_idle();
    n_checks++;
    if (waits !== 1) begin
      n_fail++; $display("FAIL rd40_waits: got %0d expected 1", waits);
    end
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL rd40_pslverr: got %b expected 1", err);
    end
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL rd40_prdata: got %h expected 00000000", rd);
    end
    // Out-of-range write must not alias onto word 0 (0x40 index truncates to 0).
    apb_xfer(1'b1, 8'h40, 32'hBADBAD00, rd, err, waits);
    go_idle();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL wr40_pslverr: got %b expected 1", err);
    end
    apb_xfer(1'b0, 8'h00, 32'h0, rd, err, waits);
    go_idle();
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL rd00_after_wr40: got %h expected 00000000", rd);
    end
    apb_xfer(1'b0, 8'h08, 32'h0, rd, err, waits);
    go_idle();
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd08_after_oor: got %h expected deadbeef", rd);
    end
    apb_xfer(1'b0, 8'h3C, 32'h0, rd, err, waits);
    go_idle();
    n_checks++;
    if (err !== 1'b0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL rd3c_last_word: got err=%b data=%h expected err=0 data=00000000",
                         err, rd);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    logic        err;
    int          waits;
    apb_xfer(1'b1, 8'h04, 32'hCAFEF00D, rd, err, waits);
    go_idle();
    apb_xfer(1'b1, 8'h05, 32'h12345678, rd, err, waits);
    go_idle();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL wr05_pslverr: got %b expected 1", err);
    end
    apb_xfer(1'b0, 8'h04, 32'h0, rd, err, waits);
    go_idle();
    n_checks++;
    if (err !== 1'b0 || rd !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL rd04_after_misaligned: got err=%b data=%h expected err=0 data=cafef00d",
                         err, rd);
    end
    apb_xfer(1'b0, 8'h06, 32'h0, rd, err, waits);
    go_idle();
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL rd06_misaligned: got err=%b data=%h expected err=1 data=00000000",
                         err, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        err;
    int          w1;
    int          w2;
    apb_xfer(1'b1, 8'h00, 32'h000000AA, rd, err, w1);
    apb_xfer(1'b0, 8'h00, 32'h0, rd, err, w2);
    go_idle();
    n_checks++;
    if (w1 !== 1 || w2 !== 1) begin
      n_fail++; $display("FAIL b2b_waits: got %0d/%0d expected 1/1", w1, w2);
    end
    n_checks++;
    if (rd !== 32'h000000AA) begin
      n_fail++; $display("FAIL b2b_prdata: got %h expected 000000aa", rd);
    end
  endtask

  task automatic test_no_setup();
    int bad;
    bad = 0;
    @(negedge pclk);
    pselx   = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    repeat (4) begin
      @(negedge pclk);
      if (pready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL penable_no_setup: got %0d pready-high cycles expected 0", bad);
    end
    go_idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic        err;
    int          waits;
    int          bad;
    bad = 0;
    @(negedge pclk);
    pselx   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h0C;
    pwdata  = 32'hFFFFFFFF;
    @(negedge pclk);
    penable = 1'b1;
    n_checks++;
    if (pready !== 1'b0) begin
      n_fail++; $display("FAIL abort_wait_pready: got %b expected 0", pready);
    end
    #2;
    pselx   = 1'b0;
    penable = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      if (pready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL abort_pready: got %0d pready-high cycles expected 0", bad);
    end
    apb_xfer(1'b0, 8'h0C, 32'h0, rd, err, waits);
    go_idle();
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL abort_rd0c: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        err;
    int          waits;
    apb_xfer(1'b1, 8'h00, 32'h00000011, rd, err, waits);
    go_idle();
    apb_xfer(1'b0, 8'h00, 32'h0, rd, err, waits);
    n_checks++;
    if (rd !== 32'h00000011) begin
      n_fail++; $display("FAIL pre_reset_rd00: got %h expected 00000011", rd);
    end
    // Pull reset between clock edges while pready/prdata are live.
    #2;
    preset_n = 1'b0;
    #1;
    n_checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
      n_fail++; $display("FAIL async_reset_outputs: got pready=%b pslverr=%b prdata=%h expected 0/0/0",
                         pready, pslverr, prdata);
    end
    @(negedge pclk);
    pselx   = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    apb_xfer(1'b0, 8'h00, 32'h0, rd, err, waits);
    go_idle();
    n_checks++;
    if (waits !== 1 || err !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_xfer: got waits=%0d err=%b expected 1/0", waits, err);
    end
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_rd00: got %h expected 00000000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_misaligned();
    test_back_to_back();
    test_no_setup();
    test_abort();
    test_reset_mid();
    repeat (2) @(negedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
